// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Sequences ALU operations for the EX stage. The ALUOp/funct pair is decoded
// with the ALU-control encoding. and/or/add/sub take one execute cycle. mul is
// an iterative shift-add that runs for WIDTH cycles. Requests and results use
// valid/ready handshakes.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-low
//   req_valid_i  request present
//   req_ready_o  sequencer idle and able to accept a request
//   ALUOp_i      01 add, 10 sub, 00 R-type (decode funct_i), 11 reserved
//   funct_i      100100 and, 100101 or, 100000 add, 100010 sub, 011000 mul
//   data1_i      operand A
//   data2_i      operand B
//   flush_i      synchronous abort of the in-flight op, also blocks an accept
//   res_valid_o  result valid (state DONE)
//   res_ready_i  consumer accepts the result
//   data_o       result, modulo 2**WIDTH
//   zero_o       data_o == 0, updated on entry to DONE
//   err_o        illegal op, updated on entry to DONE
//   busy_o       state != IDLE
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       ALUOp_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             err_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL, ST_DONE} state_t;
    typedef enum logic [2:0] {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL, OP_ILL} op_t;

    // ALU-control decode; anything not listed is reported as illegal
    function automatic op_t decode_op(input logic [1:0] aluop, input logic [5:0] funct);
        op_t op;
        case (aluop)
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            2'b00: begin
                case (funct)
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b011000: op = OP_MUL;
                    default:   op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
        return op;
    endfunction

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_r;
    state_t             state_s;
    op_t                op_r;
    op_t                dec_op_s;
    logic [WIDTH-1:0]   mcand_r;    // operand A; shifted left during mul
    logic [WIDTH-1:0]   mplier_r;   // operand B; shifted right during mul
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   acc_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   exec_res_s;
    logic               exec_err_s;
    logic               accept_s;
    logic [WIDTH-1:0]   data_r;
    logic               zero_r;
    logic               err_r;

    assign dec_op_s    = decode_op(ALUOp_i, funct_i);
    assign accept_s    = (state_r == ST_IDLE) & req_valid_i & ~flush_i;
    assign req_ready_o = (state_r == ST_IDLE);
    assign res_valid_o = (state_r == ST_DONE);
    assign busy_o      = (state_r != ST_IDLE);
    assign data_o      = data_r;
    assign zero_o      = zero_r;
    assign err_o       = err_r;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; flush wins over every other transition
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = (dec_op_s == OP_MUL) ? ST_MUL : ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (flush_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_MUL: begin
                if (flush_i) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_MUL;
                end
            end
            ST_DONE: begin
                if (flush_i || res_ready_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Single-cycle result for the non-mul ops; illegal ops yield zero
    always_comb begin
        exec_res_s = {WIDTH{1'b0}};
        exec_err_s = 1'b0;
        case (op_r)
            OP_AND:  exec_res_s = mcand_r & mplier_r;
            OP_OR:   exec_res_s = mcand_r | mplier_r;
            OP_ADD:  exec_res_s = mcand_r + mplier_r;
            OP_SUB:  exec_res_s = mcand_r - mplier_r;
            default: begin
                exec_res_s = {WIDTH{1'b0}};
                exec_err_s = 1'b1;
            end
        endcase
    end

    // One shift-add iteration: add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Operand latch, multiply datapath and registered result outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_r     <= OP_ILL;
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            data_r   <= {WIDTH{1'b0}};
            zero_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r     <= dec_op_s;
                        mcand_r  <= data1_i;
                        mplier_r <= data2_i;
                        acc_r    <= {WIDTH{1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                    end
                end
                ST_EXEC: begin
                    if (!flush_i) begin
                        data_r <= exec_res_s;
                        zero_r <= (exec_res_s == {WIDTH{1'b0}});
                        err_r  <= exec_err_s;
                    end
                end
                ST_MUL: begin
                    if (!flush_i) begin
                        acc_r    <= acc_next_s;
                        mcand_r  <= mcand_r << 1;
                        mplier_r <= mplier_r >> 1;
                        cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (cnt_r == CNT_LAST) begin
                            data_r <= acc_next_s;
                            zero_r <= (acc_next_s == {WIDTH{1'b0}});
                            err_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    // DONE: results held stable until the handshake
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [1:0]       ALUOp_i;
    logic [5:0]       funct_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             flush_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;
    logic             err_o;
    logic             busy_o;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             err;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .ALUOp_i     (ALUOp_i),
        .funct_i     (funct_i),
        .data1_i     (data1_i),
        .data2_i     (data2_i),
        .flush_i     (flush_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .data_o      (data_o),
        .zero_o      (zero_o),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour written directly from the ALU encoding
    function automatic exp_t model(input logic [1:0] aluop, input logic [5:0] funct,
                                   input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        e.err  = 1'b0;
        e.data = '0;
        if (aluop == 2'b01) e.data = a + b;
        else if (aluop == 2'b10) e.data = a - b;
        else if (aluop == 2'b11) e.err = 1'b1;
        else if (funct == 6'b100100) e.data = a & b;
        else if (funct == 6'b100101) e.data = a | b;
        else if (funct == 6'b100000) e.data = a + b;
        else if (funct == 6'b100010) e.data = a - b;
        else if (funct == 6'b011000) e.data = a * b;
        else e.err = 1'b1;
        e.zero = (e.data == '0);
        return e;
    endfunction

    task automatic drive_req(input logic [1:0] aluop, input logic [5:0] funct,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        ALUOp_i     = aluop;
        funct_i     = funct;
        data1_i     = a;
        data2_i     = b;
        req_valid_i = 1'b1;
    endtask

    // Full transaction: accept, wait for result, hold res_ready low for 'hold' cycles, handshake
    task automatic run_op(input string tag, input logic [1:0] aluop, input logic [5:0] funct,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold);
        exp_t e;
        exp_t got;
        int   cyc;
        int   lat;
        e   = model(aluop, funct, a, b);
        lat = (aluop == 2'b00 && funct == 6'b011000) ? WIDTH + 1 : 2;
        chk({tag, "_ready_idle"}, req_ready_o, 1'b1);
        drive_req(aluop, funct, a, b);
        tick;
        req_valid_i = 1'b0;
        sb_q.push_back(e);
        chk({tag, "_busy"}, busy_o, 1'b1);
        cyc = 1;
        while (!res_valid_o && cyc < 200) begin
            tick;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, lat);
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_data"}, data_o, e.data);
            chk({tag, "_hold_ready"}, req_ready_o, 1'b0);
            chk({tag, "_hold_valid"}, res_valid_o, 1'b1);
            tick;
        end
        res_ready_i = 1'b1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            got = sb_q.pop_front();
            chk({tag, "_data"}, data_o, got.data);
            chk({tag, "_zero"}, zero_o, got.zero);
            chk({tag, "_err"}, err_o, got.err);
        end
        tick;
        res_ready_i = 1'b0;
        chk({tag, "_valid_drop"}, res_valid_o, 1'b0);
        chk({tag, "_ready_back"}, req_ready_o, 1'b1);
        chk({tag, "_zero_hold"}, zero_o, e.zero);
        chk({tag, "_err_hold"}, err_o, e.err);
    endtask

    initial begin
        logic seen_valid;
        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        ALUOp_i     = 2'b00;
        funct_i     = 6'b000000;
        data1_i     = '0;
        data2_i     = '0;
        flush_i     = 1'b0;
        res_ready_i = 1'b0;
        #2;
        chk("rst_data", data_o, '0);
        chk("rst_valid", res_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ready", req_ready_o, 1'b1);
        chk("rst_err", err_o, 1'b0);
        tick;
        tick;
        rst_i = 1'b1;
        tick;

        // Basic ops, wrap to zero, negative mul, held result
        run_op("add_wrap", 2'b00, 6'b100000, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op("mul_neg", 2'b00, 6'b011000, 32'hFFFF_FFFD, 32'h0000_0005, 0);
        chk("mul_neg_const", data_o, 32'hFFFF_FFF1);
        run_op("sub_hold", 2'b10, 6'b000000, 32'h0000_0005, 32'h0000_0007, 4);
        chk("sub_const", data_o, 32'hFFFF_FFFE);
        run_op("or_op", 2'b00, 6'b100101, 32'h0000_1200, 32'h0000_0034, 0);
        run_op("add_op", 2'b01, 6'b111111, 32'h0000_0064, 32'h0000_0023, 0);
        run_op("mul_7x9", 2'b00, 6'b011000, 32'h0000_0007, 32'h0000_0009, 1);
        run_op("ill_aluop", 2'b11, 6'b100000, 32'h0000_0001, 32'h0000_0001, 0);
        run_op("ill_funct", 2'b00, 6'b111111, 32'h0000_0001, 32'h0000_0001, 0);

        // Reset in the middle of a multiply: everything clears at once
        drive_req(2'b00, 6'b011000, 32'h0000_0007, 32'h0000_0009);
        tick;
        req_valid_i = 1'b0;
        repeat (4) tick;
        chk("mid_mul_busy", busy_o, 1'b1);
        rst_i = 1'b0;
        #1;
        chk("arst_data", data_o, '0);
        chk("arst_zero", zero_o, 1'b0);
        chk("arst_err", err_o, 1'b0);
        chk("arst_valid", res_valid_o, 1'b0);
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_ready", req_ready_o, 1'b1);
        tick;
        rst_i = 1'b1;
        tick;

        // Flush in IDLE blocks the accept
        drive_req(2'b01, 6'b000000, 32'h0000_0003, 32'h0000_0004);
        flush_i = 1'b1;
        tick;
        req_valid_i = 1'b0;
        flush_i = 1'b0;
        chk("idle_flush_busy", busy_o, 1'b0);

        // Flush during multiply: abort, no result produced
        drive_req(2'b00, 6'b011000, 32'h0000_0007, 32'h0000_0009);
        tick;
        req_valid_i = 1'b0;
        repeat (10) tick;
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
        chk("flush_busy", busy_o, 1'b0);
        chk("flush_ready", req_ready_o, 1'b1);
        seen_valid = 1'b0;
        repeat (40) begin
            if (res_valid_o) seen_valid = 1'b1;
            tick;
        end
        chk("flush_no_valid", seen_valid, 1'b0);
        chk("flush_data_kept", data_o, '0);
        run_op("and_after", 2'b00, 6'b100100, 32'h0000_00F0, 32'h0000_003C, 0);
        chk("and_const", data_o, 32'h0000_0030);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
